// File: rtl/cpu_pkg.sv
// Shared pipeline constants: ALU mode encodings, ALU_OP classes, funct and opcode values.
package cpu_pkg;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_RTYPE = 2'b10,
        ALU_OP_ITYPE = 2'b11
    } alu_op_e;

    localparam logic [2:0] MOD_AND  = 3'b000;
    localparam logic [2:0] MOD_OR   = 3'b001;
    localparam logic [2:0] MOD_SLT  = 3'b010;
    localparam logic [2:0] MOD_NOR  = 3'b011;
    localparam logic [2:0] MOD_ADD  = 3'b100;
    localparam logic [2:0] MOD_ADDU = 3'b101;
    localparam logic [2:0] MOD_SUB  = 3'b110;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;

    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;

endpackage

// File: rtl/alu_ctrl.sv
// Combinational ALU control: maps alu_op/funct/opcode to ALU mode, overflow enable
// and an illegal-encoding flag. Not qualified by slot validity.
module alu_ctrl
    import cpu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    input  logic [5:0] opcode,
    output logic [2:0] alu_mod,
    output logic       ovf_en,
    output logic       illegal
);

    always_comb begin
        alu_mod = MOD_ADDU;
        ovf_en  = 1'b0;
        illegal = 1'b0;
        unique case (alu_op)
            ALU_OP_ADD: alu_mod = MOD_ADDU;
            ALU_OP_SUB: alu_mod = MOD_SUB;
            ALU_OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD:  begin alu_mod = MOD_ADD; ovf_en = 1'b1; end
                    FUNCT_ADDU: alu_mod = MOD_ADDU;
                    FUNCT_SUB:  begin alu_mod = MOD_SUB; ovf_en = 1'b1; end
                    FUNCT_SUBU: alu_mod = MOD_SUB;
                    FUNCT_AND:  alu_mod = MOD_AND;
                    FUNCT_OR:   alu_mod = MOD_OR;
                    FUNCT_NOR:  alu_mod = MOD_NOR;
                    FUNCT_SLT:  alu_mod = MOD_SLT;
                    default:    illegal = 1'b1;
                endcase
            end
            ALU_OP_ITYPE: begin
                case (opcode)
                    OPC_ADDI:  begin alu_mod = MOD_ADD; ovf_en = 1'b1; end
                    OPC_ADDIU: alu_mod = MOD_ADDU;
                    OPC_SLTI:  alu_mod = MOD_SLT;
                    OPC_ANDI:  alu_mod = MOD_AND;
                    OPC_ORI:   alu_mod = MOD_OR;
                    default:   illegal = 1'b1;
                endcase
            end
            default: alu_mod = MOD_ADDU;
        endcase
    end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and ALU mode decode.
module ex_issue_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_rs_val,
    input  logic [DW-1:0] in_rt_val,
    input  logic [DW-1:0] in_imm,
    input  logic [RW-1:0] in_rs,
    input  logic [RW-1:0] in_rt,
    input  logic [RW-1:0] in_rd,
    input  logic [5:0]    in_opcode,
    input  logic [5:0]    in_funct,
    input  logic [1:0]    in_alu_op,
    input  logic          in_alu_src,
    input  logic          in_reg_dst,
    input  logic          in_reg_write,
    input  logic          exm_reg_write,
    input  logic [RW-1:0] exm_rd,
    input  logic [DW-1:0] exm_result,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_result,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_mod,
    output logic          ovf_en,
    output logic [DW-1:0] store_data,
    output logic [RW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic          ex_valid,
    output logic          ex_illegal
);

    logic          valid_q;
    logic [DW-1:0] rs_val_q, rt_val_q, imm_q;
    logic [RW-1:0] rs_q, rt_q, rd_q;
    logic [5:0]    opcode_q, funct_q;
    logic [1:0]    alu_op_q;
    logic          alu_src_q, reg_dst_q, reg_write_q;

    // Flush loads the same all-zero bubble as reset.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            valid_q     <= 1'b0;
            rs_val_q    <= '0;
            rt_val_q    <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            opcode_q    <= '0;
            funct_q     <= '0;
            alu_op_q    <= '0;
            alu_src_q   <= 1'b0;
            reg_dst_q   <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= in_valid;
            rs_val_q    <= in_rs_val;
            rt_val_q    <= in_rt_val;
            imm_q       <= in_imm;
            rs_q        <= in_rs;
            rt_q        <= in_rt;
            rd_q        <= in_rd;
            opcode_q    <= in_opcode;
            funct_q     <= in_funct;
            alu_op_q    <= in_alu_op;
            alu_src_q   <= in_alu_src;
            reg_dst_q   <= in_reg_dst;
            reg_write_q <= in_reg_write;
        end
    end

    logic [DW-1:0] fwd_rs, fwd_rt;

    // EX/MEM beats MEM/WB; $0 is never forwarded.
    always_comb begin
        fwd_rs = rs_val_q;
        if (exm_reg_write && exm_rd != '0 && exm_rd == rs_q) begin
            fwd_rs = exm_result;
        end else if (wb_reg_write && wb_rd != '0 && wb_rd == rs_q) begin
            fwd_rs = wb_result;
        end
        fwd_rt = rt_val_q;
        if (exm_reg_write && exm_rd != '0 && exm_rd == rt_q) begin
            fwd_rt = exm_result;
        end else if (wb_reg_write && wb_rd != '0 && wb_rd == rt_q) begin
            fwd_rt = wb_result;
        end
    end

    logic       dec_ovf_en;
    logic       dec_illegal;

    alu_ctrl u_alu_ctrl (
        .alu_op  (alu_op_q),
        .funct   (funct_q),
        .opcode  (opcode_q),
        .alu_mod (alu_mod),
        .ovf_en  (dec_ovf_en),
        .illegal (dec_illegal)
    );

    always_comb begin
        alu_a        = fwd_rs;
        store_data   = fwd_rt;
        alu_b        = alu_src_q ? imm_q : fwd_rt;
        ex_rd        = reg_dst_q ? rd_q : rt_q;
        ex_reg_write = reg_write_q & valid_q;
        ex_valid     = valid_q;
        ovf_en       = dec_ovf_en & valid_q;
        ex_illegal   = dec_illegal & valid_q;
    end

endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- ID/EX pipeline register plus execute-side operand logic for the 5-stage pipeline.
- Captures decoded instruction fields from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Decodes the 3-bit ALU mode and drives the operand and mode inputs of the combinational ALU in EX.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  hold the ID/EX register contents.
- flush  in  1  load a bubble into ID/EX.
- in_valid  in  1  ID slot holds a real instruction.
- in_rs_val  in  DW  register-file rs read data.
- in_rt_val  in  DW  register-file rt read data.
- in_imm  in  DW  sign-extended immediate.
- in_rs  in  RW  rs address.
- in_rt  in  RW  rt address.
- in_rd  in  RW  rd address.
- in_opcode  in  6  instruction opcode.
- in_funct  in  6  R-type funct.
- in_alu_op  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type, 11 I-type arith.
- in_alu_src  in  1  1 selects the immediate as operand B.
- in_reg_dst  in  1  1 selects rd as destination, 0 selects rt.
- in_reg_write  in  1  instruction writes the register file.
- exm_reg_write  in  1  EX/MEM write enable.
- exm_rd  in  RW  EX/MEM destination.
- exm_result  in  DW  EX/MEM ALU result.
- wb_reg_write  in  1  MEM/WB write enable.
- wb_rd  in  RW  MEM/WB destination.
- wb_result  in  DW  MEM/WB writeback data.
- alu_a  out  DW  ALU operand a.
- alu_b  out  DW  ALU operand b.
- alu_mod  out  3  ALU mode.
- ovf_en  out  1  ALU overflow flag is architecturally significant.
- store_data  out  DW  forwarded rt value, passed to MEM for stores.
- ex_rd  out  RW  selected destination register.
- ex_reg_write  out  1  destination write enable, qualified by ex_valid.
- ex_valid  out  1  EX slot valid.
- ex_illegal  out  1  unknown funct or opcode in a valid slot.

Behaviour:
- Register update at posedge clk, priority: reset > flush > stall > load.
  - !rst_n: every ID/EX field cleared to 0, including valid and reg_write.
  - flush: same clearing as reset (bubble). Flush wins over a simultaneous stall.
  - stall: all fields hold.
  - otherwise: all in_* fields captured.
- Reset values of outputs:
  - alu_a=0, alu_b=0, store_data=0, ex_rd=0.
  - ex_reg_write=0, ex_valid=0, ex_illegal=0.
  - Decode of the zeroed fields: alu_mod=101, ovf_en=0.
- Latency: one cycle from ID inputs to EX outputs. Outputs are combinational from the registered fields plus the live forwarding inputs.
- Forwarding, applied independently to rs and rt:
  - EX/MEM hit: exm_reg_write && exm_rd!=0 && exm_rd==src. Selects exm_result.
  - Otherwise MEM/WB hit: wb_reg_write && wb_rd!=0 && wb_rd==src. Selects wb_result.
  - Otherwise the registered value.
  - EX/MEM takes priority when both hit. $0 is never forwarded.
- alu_a = forwarded rs.
- store_data = forwarded rt.
- alu_b = registered imm when alu_src, else forwarded rt.
- ex_rd = reg_dst ? rd : rt.
- ex_reg_write = reg_write & valid.
- ALU mode decode from alu_op:
  - 00 -> 101, ovf_en 0.
  - 01 -> 110, ovf_en 0.
  - 10, by funct:
    - 100000 add -> 100, ovf_en 1.
    - 100001 addu -> 101.
    - 100010 sub -> 110, ovf_en 1.
    - 100011 subu -> 110, ovf_en 0.
    - 100100 and -> 000.
    - 100101 or -> 001.
    - 100111 nor -> 011.
    - 101010 slt -> 010.
  - 11, by opcode:
    - 001000 addi -> 100, ovf_en 1.
    - 001001 addiu -> 101.
    - 001010 slti -> 010.
    - 001100 andi -> 000.
    - 001101 ori -> 001.
- Any other funct or opcode: alu_mod=101, ovf_en=0, ex_illegal=valid.
- ovf_en is forced to 0 when valid=0.
- Stalled slot: outputs remain decoded from the held fields, and forwarding keeps tracking the live exm_*/wb_* inputs.

Decomposition:
- Shared cpu_pkg holds:
  - ALU mode constants: MOD_AND, MOD_OR, MOD_SLT, MOD_NOR, MOD_ADD, MOD_ADDU, MOD_SUB.
  - ALU_OP_* encodings.
  - FUNCT_* and OPC_* constants.
- One sub-module, alu_ctrl: purely combinational alu_op/funct/opcode -> {alu_mod, ovf_en, illegal}. It is reusable by a later branch-compare unit.
- Forwarding muxes stay inline.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with in_valid=1 -> ex_valid=0, ex_reg_write=0, alu_a=0, alu_mod=101.
- R-type add: rs=2, rt=3, rd=4, vals 5/7, funct 100000, no hazards -> next cycle alu_a=5, alu_b=7, alu_mod=100, ovf_en=1, ex_rd=4, ex_reg_write=1.
- Double hazard: in EX, rs=rt=8; exm_rd=8 with exm_result=0x11; wb_rd=8 with wb_result=0x22.
  - Both write enables set -> alu_a=alu_b=0x11.
  - Then clear exm_reg_write -> 0x22.
- $0 guard: rs=0, exm_rd=0, exm_reg_write=1, exm_result=0xFFFF -> alu_a = registered rs value 0.
- Stall/flush: stall=1 for 3 cycles while inputs change -> outputs unchanged. Then stall=1 with flush=1 -> ex_valid=0, ex_reg_write=0 the next cycle.
- I-type/illegal:
  - addi with alu_src=1, imm=0xFFFFFFFC -> alu_b=0xFFFFFFFC, alu_mod=100, ex_rd=rt.
  - funct 111111 -> alu_mod=101, ex_illegal=1.
